// File: rtl/br_flow_demux_select_reg.sv
// Registered 1:N ready-valid demux: each accepted beat goes to the pop lane named by push_select.
// Optional BR_FLOW_DEMUX_SELECT_REG_SKID_EN adds a 1-entry skid so push_ready comes straight from a flop.
module br_flow_demux_select_reg #(
  parameter int NumRequesters = 2,
  parameter int BitWidth      = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic                              push_ready,
  input  logic                              push_valid,
  input  logic [$clog2(NumRequesters)-1:0]  push_select,
  input  logic [BitWidth-1:0]               push_data,
  input  logic [NumRequesters-1:0]          pop_ready,
  output logic [NumRequesters-1:0]          pop_valid,
  output logic [NumRequesters*BitWidth-1:0] pop_data
);
  localparam int SelectWidth = $clog2(NumRequesters);

  if (NumRequesters < 2) begin : gen_bad_num_requesters
    $error("NumRequesters must be >= 2");
  end
  if (BitWidth < 1) begin : gen_bad_bit_width
    $error("BitWidth must be >= 1");
  end

  logic                   out_valid_q;
  logic [SelectWidth-1:0] dest_q;
  logic [BitWidth-1:0]    data_q;
  logic                   pop_ready_sel;
  logic                   pop_fire;
  logic                   push_fire;
  logic                   push_load;
  logic                   sel_in_range;

  assign sel_in_range = (32'(push_select) < NumRequesters);
  assign push_fire    = push_valid && push_ready;
  // Out-of-range selects are consumed but never loaded anywhere.
  assign push_load    = push_fire && sel_in_range;

  always_comb begin
    pop_ready_sel = 1'b0;
    pop_valid     = '0;
    for (int unsigned i = 0; i < NumRequesters; i++) begin
      if (dest_q == SelectWidth'(i)) begin
        pop_ready_sel = pop_ready[i];
        pop_valid[i]  = out_valid_q;
      end
    end
  end

  assign pop_fire = out_valid_q && pop_ready_sel;
  assign pop_data = {NumRequesters{data_q}};

`ifdef BR_FLOW_DEMUX_SELECT_REG_SKID_EN
  logic                   skid_valid_q;
  logic [SelectWidth-1:0] skid_dest_q;
  logic [BitWidth-1:0]    skid_data_q;
  logic                   out_free;

  assign push_ready = !skid_valid_q;
  assign out_free   = !out_valid_q || pop_fire;

  // Skid is only ever full while the output is held, so a free output drains skid first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      dest_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_dest_q  <= '0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        dest_q       <= skid_dest_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= push_load;
        if (push_load) dest_q <= push_select;
      end
    end else if (push_load) begin
      skid_valid_q <= 1'b1;
      skid_dest_q  <= push_select;
    end
  end

  always_ff @(posedge clk) begin
    if (out_free) begin
      if (skid_valid_q) data_q <= skid_data_q;
      else if (push_load) data_q <= push_data;
    end else if (push_load) begin
      skid_data_q <= push_data;
    end
  end
`else
  assign push_ready = !out_valid_q || pop_ready_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dest_q      <= '0;
    end else if (push_fire) begin
      out_valid_q <= sel_in_range;
      if (push_load) dest_q <= push_select;
    end else if (pop_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_load) data_q <= push_data;
  end
`endif

`ifndef SYNTHESIS
  logic                     hist_push_stall;
  logic [SelectWidth-1:0]   hist_push_select;
  logic [BitWidth-1:0]      hist_push_data;
  logic [NumRequesters-1:0] hist_pop_stall;
  logic [BitWidth-1:0]      hist_data;
  int unsigned              in_flight;
  int unsigned              occupancy;

`ifdef BR_FLOW_DEMUX_SELECT_REG_SKID_EN
  assign occupancy = 32'(out_valid_q) + 32'(skid_valid_q);
`else
  assign occupancy = 32'(out_valid_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_push_stall <= 1'b0;
      hist_pop_stall  <= '0;
      in_flight       <= 0;
    end else begin
      select_in_range_a: assert (!push_valid || sel_in_range);
      push_valid_hold_a: assert (!hist_push_stall || push_valid);
      push_stable_a: assert (!hist_push_stall ||
                             (push_select == hist_push_select && push_data == hist_push_data));
      pop_onehot0_a: assert ($onehot0(pop_valid));
      pop_stable_a: assert (((hist_pop_stall & ~pop_valid) == '0) &&
                            (hist_pop_stall == '0 || data_q == hist_data));
      no_loss_dup_a: assert (in_flight == occupancy);
      hist_push_stall  <= push_valid && !push_ready;
      hist_push_select <= push_select;
      hist_push_data   <= push_data;
      hist_pop_stall   <= pop_valid & ~pop_ready;
      hist_data        <= data_q;
      in_flight        <= in_flight + 32'(push_load) - 32'(|(pop_valid & pop_ready));
    end
  end
`endif
endmodule

// File: tb/tb_br_flow_demux_select_reg.sv
// Directed and short random checks of br_flow_demux_select_reg with 4 lanes of 8-bit data.
module tb_br_flow_demux_select_reg;
  localparam int N = 4;
  localparam int W = 8;
`ifdef BR_FLOW_DEMUX_SELECT_REG_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         push_ready;
  logic         push_valid;
  logic [1:0]   push_select;
  logic [W-1:0] push_data;
  logic [N-1:0] pop_ready;
  logic [N-1:0] pop_valid;
  logic [N*W-1:0] pop_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  br_flow_demux_select_reg #(.NumRequesters(N), .BitWidth(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_ready(push_ready), .push_valid(push_valid),
    .push_select(push_select), .push_data(push_data),
    .pop_ready(pop_ready), .pop_valid(pop_valid), .pop_data(pop_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] lane(input int i);
    return pop_data[W*i +: W];
  endfunction

  logic [9:0] sbq[$];
  logic [9:0] exp_beat;
  bit         held;

  initial begin
    rst_n = 1'b0; push_valid = 1'b1; push_select = 2'd0; push_data = 8'h11; pop_ready = 4'hF;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_pop_valid", 32'(pop_valid), 32'h0);
      chk("rst_push_ready", 32'(push_ready), 32'h1);
    end
    rst_n = 1'b1;
    cyc();
    chk("rst_first_valid", 32'(pop_valid), 32'h1);
    chk("rst_first_data", 32'(lane(0)), 32'h11);
    push_valid = 1'b0;
    cyc();
    chk("rst_drain", 32'(pop_valid), 32'h0);

    // streaming to each lane back to back
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1; push_select = 2'(i); push_data = 8'(8'hA + i);
      #1;
      chk("stream_push_ready", 32'(push_ready), 32'h1);
      cyc();
      chk("stream_pop_valid", 32'(pop_valid), 32'(1 << i));
      chk("stream_data", 32'(lane(i)), 32'(8'hA + i));
    end
    push_valid = 1'b0;
    cyc();
    chk("stream_idle", 32'(pop_valid), 32'h0);

    // backpressure on lane 2
    pop_ready = 4'b1011; push_valid = 1'b1; push_select = 2'd2; push_data = 8'h05;
    #1;
    chk("bp_accept_ready", 32'(push_ready), 32'h1);
    cyc();
    push_select = 2'd0; push_data = 8'h06;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_pop_valid", 32'(pop_valid), 32'b0100);
      chk("bp_data", 32'(lane(2)), 32'h05);
      chk("bp_push_ready", 32'(push_ready), 32'((Skid && k == 0) ? 1 : 0));
      cyc();
      if (Skid && k == 0) push_valid = 1'b0;
    end
    pop_ready = 4'hF;
    #1;
    chk("bp_release_ready", 32'(push_ready), 32'(Skid ? 0 : 1));
    cyc();
    push_valid = 1'b0;
    chk("bp_next_valid", 32'(pop_valid), 32'b0001);
    chk("bp_next_data", 32'(lane(0)), 32'h06);
    cyc();
    chk("bp_idle", 32'(pop_valid), 32'h0);

    // head-of-line: lane 3 waits behind stalled lane 1
    pop_ready = 4'b1000; push_valid = 1'b1; push_select = 2'd1; push_data = 8'h21;
    cyc();
    push_select = 2'd3; push_data = 8'h23;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hol_pop_valid", 32'(pop_valid), 32'b0010);
      chk("hol_data", 32'(lane(1)), 32'h21);
      chk("hol_push_ready", 32'(push_ready), 32'((Skid && k == 0) ? 1 : 0));
      cyc();
      if (Skid && k == 0) push_valid = 1'b0;
    end
    pop_ready = 4'b1010;
    cyc();
    push_valid = 1'b0;
    chk("hol_second_valid", 32'(pop_valid), 32'b1000);
    chk("hol_second_data", 32'(lane(3)), 32'h23);
    pop_ready = 4'b1000;
    cyc();
    chk("hol_idle", 32'(pop_valid), 32'h0);

    // asynchronous reset while holding a beat
    pop_ready = 4'b0000; push_valid = 1'b1; push_select = 2'd1; push_data = 8'h31;
    cyc();
    push_valid = 1'b0;
    chk("mid_held", 32'(pop_valid), 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 32'(pop_valid), 32'h0);
    chk("mid_async_ready", 32'(push_ready), 32'h1);
    pop_ready = 4'hF;
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("mid_discarded", 32'(pop_valid), 32'h0);
    end

    // random traffic against an in-order scoreboard
    held = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!held) begin
        push_valid  = 1'($urandom_range(0, 1));
        push_select = 2'($urandom_range(0, 3));
        push_data   = 8'($urandom_range(0, 255));
      end
      pop_ready = 4'($urandom_range(0, 15));
      #1;
      chk("rnd_onehot0", 32'($onehot0(pop_valid)), 32'h1);
      for (int i = 0; i < N; i++) begin
        if (pop_valid[i] && pop_ready[i]) begin
          exp_beat = (sbq.size() > 0) ? sbq.pop_front() : 10'h3FF;
          chk("rnd_pop", 32'({2'(i), lane(i)}), 32'(exp_beat));
        end
      end
      if (push_valid && push_ready) sbq.push_back({push_select, push_data});
      held = push_valid && !push_ready;
      cyc();
    end
    push_valid = 1'b0; pop_ready = 4'hF;
    for (int c = 0; c < 4; c++) begin
      #1;
      for (int i = 0; i < N; i++) begin
        if (pop_valid[i]) begin
          exp_beat = (sbq.size() > 0) ? sbq.pop_front() : 10'h3FF;
          chk("rnd_drain_pop", 32'({2'(i), lane(i)}), 32'(exp_beat));
        end
      end
      cyc();
    end
    chk("rnd_all_delivered", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
